bright_sub_serial: RTL
======================

BRIGHT_SUB_SERIAL -- requirements
Module: bright_sub_serial

Interface
REQ-001 Parameter PIX_W, default 8, SHALL set the pixel width in bits (legal range 4..16).
REQ-002 Parameter STEP_W, default 3, SHALL set the decrement-step width in bits (legal range 1..PIX_W).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 in_valid  input  1  SHALL indicate pixel_in/step_in are valid.
REQ-006 in_ready  output  1  SHALL indicate the block can accept an operand pair.
REQ-007 pixel_in  input  PIX_W  SHALL be the unsigned pixel brightness.
REQ-008 step_in  input  STEP_W  SHALL be the unsigned brightness decrement.
REQ-009 out_valid  output  1  SHALL indicate pixel_out/underflow are valid.
REQ-010 out_ready  input  1  SHALL indicate the downstream consumer accepts the result.
REQ-011 pixel_out  output  PIX_W  SHALL be the darkened pixel, saturated at 0.
REQ-012 underflow  output  1  SHALL flag that step_in exceeded pixel_in.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 In IDLE, in_valid=1 at a rising edge SHALL capture pixel_in, step_in zero-extended to PIX_W, clear the borrow flop and bit counter, and enter SHIFT.
REQ-016 In SHIFT, each edge SHALL subtract one bit pair LSB-first (a - b - borrow) and shift the difference bit into the result register MSB-first so that after PIX_W edges the result is LSB-aligned.
REQ-017 The bit counter SHALL count 0..PIX_W-1; the edge at count PIX_W-1 SHALL enter DONE.
REQ-018 On that edge pixel_out SHALL load the full difference if the final borrow is 0, else all zeros with underflow=1.
REQ-019 Latency: if accepted at edge E0, out_valid SHALL be 1 in the cycle after edge E0+PIX_W (8 edges for the default).
REQ-020 In DONE, pixel_out and underflow SHALL hold stable while out_ready=0.
REQ-021 In DONE, out_ready=1 at an edge SHALL return the FSM to IDLE; no new input is accepted on that same edge.
REQ-022 Result exactness: step_in = pixel_in SHALL give pixel_out=0 with underflow=0.
REQ-023 Input changes while not in IDLE SHALL have no effect.

Reset
REQ-024 rst_n=0 at an edge SHALL force IDLE, in_ready=1, out_valid=0, pixel_out=0, underflow=0, counter=0, borrow=0.
REQ-025 Reset in SHIFT or DONE SHALL abort the operation; the result SHALL be discarded and never presented.
REQ-026 in_valid held at 1 across reset release SHALL be accepted on the first edge with rst_n=1.

Structure
REQ-027 A shared package SHALL hold the state enumeration and the default PIX_W/STEP_W constants.
REQ-028 The per-bit arithmetic SHALL be one sub-module, full_subtractor (inputs a, b, bin; outputs diff, bout), which is the bitwise counterpart of full_adder.
REQ-029 The top SHALL contain one operand register per operand, the result shift register, the borrow flop, the counter and the FSM; no combinational path SHALL run from out_ready to in_ready.

Verification
REQ-030 pixel_in=200, step_in=5 -> pixel_out=195, underflow=0, out_valid=1 after exactly 8 edges from acceptance.
REQ-031 pixel_in=3, step_in=7 -> pixel_out=0, underflow=1.
REQ-032 pixel_in=7, step_in=7 -> pixel_out=0, underflow=0; pixel_in=0, step_in=0 -> pixel_out=0, underflow=0.
REQ-033 out_ready held 0 for 5 cycles in DONE -> pixel_out/underflow stable; the new in_valid is ignored until the cycle after out_ready=1 returns the FSM to IDLE.
REQ-034 rst_n=0 asserted at SHIFT count 4 -> next cycle in_ready=1, out_valid=0, pixel_out=0; a following pair 100/1 -> 99.
REQ-035 Back-to-back pairs with in_valid=1 and out_ready=1 held high -> one result every PIX_W+2 cycles, each matching the saturating reference model for 1000 random pairs.

Source files
------------

// File: rtl/bright_sub_serial_pkg.sv
// Shared definitions for the bit-serial saturating brightness subtractor.
package bright_sub_serial_pkg;
  localparam int PIX_W_DEF  = 8;
  localparam int STEP_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/bright_sub_serial_full_subtractor.sv
// One-bit full subtractor: diff = a - b - bin, bout set when the bit borrows.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);
  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/bright_sub_serial.sv
// Bit-serial pixel darkener: pixel_out = max(pixel_in - step_in, 0), one bit per clock LSB-first.
// Result valid PIX_W edges after acceptance; held in DONE until out_ready, one operation in flight.
module bright_sub_serial
  import bright_sub_serial_pkg::*;
#(
  parameter int PIX_W  = PIX_W_DEF,
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PIX_W-1:0]  pixel_in,
  input  logic [STEP_W-1:0] step_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PIX_W-1:0]  pixel_out,
  output logic              underflow
);
  localparam int CNT_W = $clog2(PIX_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIX_W - 1);

  state_t             state_q, state_d;
  logic [PIX_W-1:0]   a_q, a_d;
  logic [PIX_W-1:0]   b_q, b_d;
  logic [PIX_W-1:0]   res_q, res_d;
  logic               borrow_q, borrow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PIX_W-1:0]   pixel_out_q, pixel_out_d;
  logic               underflow_q, underflow_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic bit_diff;
  logic bit_bout;

  full_subtractor u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (borrow_q),
    .diff (bit_diff),
    .bout (bit_bout)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    borrow_d    = borrow_q;
    cnt_d       = cnt_q;
    pixel_out_d = pixel_out_q;
    underflow_d = underflow_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = pixel_in;
          b_d      = PIX_W'(step_in);
          res_d    = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        // Difference bits enter at the MSB so the word is LSB-aligned after PIX_W shifts.
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        res_d    = {bit_diff, res_q[PIX_W-1:1]};
        borrow_d = bit_bout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d     = DONE;
          cnt_d       = '0;
          pixel_out_d = bit_bout ? '0 : res_d;
          underflow_d = bit_bout;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      borrow_q    <= 1'b0;
      cnt_q       <= '0;
      pixel_out_q <= '0;
      underflow_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      borrow_q    <= borrow_d;
      cnt_q       <= cnt_d;
      pixel_out_q <= pixel_out_d;
      underflow_q <= underflow_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign pixel_out = pixel_out_q;
  assign underflow = underflow_q;
endmodule
